lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Load/store unit between the core's memory pipeline stage and the mmu.
- Accepts one load/store request at a time through a valid/ready handshake and decodes RV32 funct3 into mmu width and sign controls.
- Pulses the mmu enables for one cycle, holds address and data until the mmu reports completion, then returns the load result or an error.
- Rejects misaligned stores and illegal funct3 values. Aborts on a timeout.

Parameters:
TIMEOUT_CYCLES, 16, maximum WAIT cycles without mmu_mem_ready before the access is aborted with an error (range 2..255).

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  high when the block can accept a request (state==IDLE)
req_write  input  1  1=store, 0=load
req_funct3  input  3  RV32 load/store funct3
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
req_rd  input  5  destination register tag
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  load result (0 for stores and errors)
resp_rd  output  5  tag of the completed request
resp_error  output  1  illegal funct3, misaligned store, or timeout
mmu_read_enable  output  1  to mmu read_enable
mmu_write_enable  output  1  to mmu write_enable
mmu_signed_read  output  1  to mmu mem_signed_read
mmu_data_width  output  2  to mmu mem_data_width (0=byte, 1=half, 3=word)
mmu_address  output  32  to mmu address
mmu_data_in  output  32  to mmu data_in
mmu_data_out  input  32  from mmu data_out
mmu_mem_ready  input  1  from mmu mem_ready

Behaviour:
- Clock and reset: clk; reset_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, so req_ready=1.
  - resp_valid, resp_error, mmu_read_enable, mmu_write_enable and mmu_signed_read = 0.
  - resp_rdata, resp_rd, mmu_address, mmu_data_in and mmu_data_width = 0.
  - Timeout counter = 0.
- Reset mid-operation: the in-flight access is abandoned. No resp_valid is produced.
- Acceptance: occurs on a clk edge with state==IDLE and req_valid=1. The block latches addr, wdata, rd, write and the decoded controls into registers that drive the mmu_* outputs.
- Decode:
  - funct3[1:0] 00→width 0, 01→width 1, 10→width 3.
  - mmu_signed_read = ~funct3[2] for loads, 0 for stores.
  - Illegal for loads: 011, 110, 111.
  - Illegal for stores: any funct3[2]=1, or 011.
- Misaligned store: addr[1:0] + width > 3. Misaligned loads are legal; the mmu handles them.
- Error at accept (illegal funct3 or misaligned store):
  - No mmu enable is asserted. State stays IDLE.
  - Next cycle: resp_valid=1, resp_error=1, resp_rdata=0.
- Otherwise the next state is ISSUE.
- States:
  - IDLE:
    - Enables are 0.
    - resp_valid is deasserted after one cycle unless a new response is being produced.
  - ISSUE:
    - If mmu_mem_ready=1: assert exactly one of mmu_read_enable or mmu_write_enable for this single cycle, then go to WAIT with counter=0.
    - If mmu_mem_ready=0: stay in ISSUE with enables 0. This wait has no timeout.
  - WAIT:
    - Enables are 0. Address, width, sign and data_in are held stable.
    - Each cycle, if mmu_mem_ready=1, the access completes:
      - Capture resp_rdata = mmu_data_out for loads, or 0 for stores.
      - resp_error=0, resp_valid=1 in the following cycle, state→IDLE.
    - Else increment the counter. When counter == TIMEOUT_CYCLES-1 and ready is still 0: resp_valid=1, resp_error=1, resp_rdata=0, state→IDLE.
- Latency (acceptance edge to resp_valid cycle):
  - 3 cycles for an aligned load or word store; the mmu is ready in the first WAIT cycle.
  - 4 cycles for a sub-word store or a misaligned load; the mmu drops ready for one cycle.
- Back-to-back: req_ready=1 in the same cycle resp_valid=1, so a new request may be accepted then.
- resp_valid is never asserted for two consecutive cycles from the same request.
- The mmu enables are never asserted outside ISSUE. Holding them longer would retrigger the mmu when it returns to ready.

Test Plan:
- Aligned LW: funct3=010, addr=0x01000008, RAM word 0xDEADBEEF → mmu_read_enable high for exactly 1 cycle, width=3, resp_valid 3 cycles after accept, resp_rdata=0xDEADBEEF, resp_error=0.
- LB/LBU: addr=0x01000003, word 0x80112233 → LB gives 0xFFFFFF80, LBU gives 0x00000080, with signed_read 1 and 0 respectively.
- SH at 0x01000002 with wdata=0x0000ABCD → mmu ready low for 1 cycle, resp 4 cycles after accept; a following LW reads 0xABCDxxxx with the low half preserved. SW at 0x01000001 → resp_error=1 next cycle and no mmu enable ever asserted.
- Misaligned LW at 0x01000005 → one read pulse, completion after ready's 0→1 transition, data stitched from two words by the mmu. Illegal load funct3=011 → resp_error=1 with no enable.
- Timeout: tie mmu_mem_ready low after ISSUE → resp_error=1, resp_rdata=0 after TIMEOUT_CYCLES WAIT cycles; state back to IDLE with req_ready=1.
- Async reset asserted in WAIT → all outputs go to reset values immediately, no resp_valid afterward. Back-to-back LW requests each receive exactly one response, with resp_rd tags 5 then 6.

Source files
------------

// File: rtl/lsu_mem_stage_if.sv
// Bundle of the core-side request/response handshake and the mmu access signals
// seen by the load/store memory stage.
interface lsu_mem_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_error;

  logic        mmu_read_enable;
  logic        mmu_write_enable;
  logic        mmu_signed_read;
  logic [1:0]  mmu_data_width;
  logic [31:0] mmu_address;
  logic [31:0] mmu_data_in;
  logic [31:0] mmu_data_out;
  logic        mmu_mem_ready;

  // The load/store stage itself.
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, req_rd,
    input  mmu_data_out, mmu_mem_ready,
    output req_ready, resp_valid, resp_rdata, resp_rd, resp_error,
    output mmu_read_enable, mmu_write_enable, mmu_signed_read, mmu_data_width,
    output mmu_address, mmu_data_in
  );

  // The environment: core pipeline plus mmu.
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, req_rd,
    output mmu_data_out, mmu_mem_ready,
    input  req_ready, resp_valid, resp_rdata, resp_rd, resp_error,
    input  mmu_read_enable, mmu_write_enable, mmu_signed_read, mmu_data_width,
    input  mmu_address, mmu_data_in
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// Load/store unit between the memory pipeline stage and the mmu: decodes RV32 funct3,
// issues a single-cycle mmu enable, waits for completion or timeout, returns one response.
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic             clk,
  input logic             reset_n,
  lsu_mem_stage_if.slave  lsu_io
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [4:0]  rd_q, rd_d;
  logic        write_q, write_d;
  logic [1:0]  width_q, width_d;
  logic        signed_q, signed_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_error_q, resp_error_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic [4:0]  resp_rd_q, resp_rd_d;
  logic        rd_en, wr_en;

  logic [2:0]  f3;
  logic [1:0]  dec_width;
  logic        dec_illegal;
  logic        dec_misalign;

  assign f3 = lsu_io.req_funct3;
  // 00 -> byte (0), 01 -> half (1), 10 -> word (3)
  assign dec_width   = {f3[1], f3[1] | f3[0]};
  assign dec_illegal = lsu_io.req_write ? (f3[2] | (&f3[1:0]))
                                        : ((&f3[1:0]) | (f3 == 3'b110));
  // Only stores must stay within one word; the mmu stitches misaligned loads.
  assign dec_misalign = lsu_io.req_write &
                        (({1'b0, lsu_io.req_addr[1:0]} + {1'b0, dec_width}) > 3'd3);

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rd_d         = rd_q;
    write_d      = write_q;
    width_d      = width_q;
    signed_d     = signed_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    resp_rd_d    = resp_rd_q;
    rd_en        = 1'b0;
    wr_en        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (lsu_io.req_valid) begin
          if (dec_illegal || dec_misalign) begin
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_rdata_d = '0;
            resp_rd_d    = lsu_io.req_rd;
          end else begin
            addr_d   = lsu_io.req_addr;
            wdata_d  = lsu_io.req_wdata;
            rd_d     = lsu_io.req_rd;
            write_d  = lsu_io.req_write;
            width_d  = dec_width;
            signed_d = ~lsu_io.req_write & ~f3[2];
            state_d  = StIssue;
          end
        end
      end
      StIssue: begin
        // Enables must stay a single-cycle pulse or the mmu retriggers on ready.
        if (lsu_io.mmu_mem_ready) begin
          rd_en   = ~write_q;
          wr_en   = write_q;
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (lsu_io.mmu_mem_ready) begin
          resp_valid_d = 1'b1;
          resp_rdata_d = write_q ? '0 : lsu_io.mmu_data_out;
          resp_rd_d    = rd_q;
          state_d      = StIdle;
        end else if (cnt_q == CntLast) begin
          resp_valid_d = 1'b1;
          resp_error_d = 1'b1;
          resp_rdata_d = '0;
          resp_rd_d    = rd_q;
          state_d      = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      write_q      <= 1'b0;
      width_q      <= '0;
      signed_q     <= 1'b0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_rd_q    <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rd_q         <= rd_d;
      write_q      <= write_d;
      width_q      <= width_d;
      signed_q     <= signed_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
      resp_rd_q    <= resp_rd_d;
    end
  end

  assign lsu_io.req_ready        = (state_q == StIdle);
  assign lsu_io.resp_valid       = resp_valid_q;
  assign lsu_io.resp_error       = resp_error_q;
  assign lsu_io.resp_rdata       = resp_rdata_q;
  assign lsu_io.resp_rd          = resp_rd_q;
  assign lsu_io.mmu_read_enable  = rd_en;
  assign lsu_io.mmu_write_enable = wr_en;
  assign lsu_io.mmu_signed_read  = signed_q;
  assign lsu_io.mmu_data_width   = width_q;
  assign lsu_io.mmu_address      = addr_q;
  assign lsu_io.mmu_data_in      = wdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: a byte-array mmu model, a table of load/store vectors with
// constant expectations, a response scoreboard, and hand sequences for timeout/reset/b2b.
module tb_lsu_mem_stage;
  localparam int unsigned Timeout = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  lsu_mem_stage_if bus ();

  lsu_mem_stage #(.TIMEOUT_CYCLES(Timeout)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .lsu_io  (bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- mmu model ----------------
  logic [7:0]  mem [0:63];
  logic        mmu_ready_q = 1'b1;
  logic [31:0] mmu_dout_q = '0;
  logic        hang = 1'b0;
  int          rd_pulses = 0;
  int          wr_pulses = 0;
  logic [1:0]  last_w = '0;
  logic        last_s = 1'b0;
  logic [31:0] last_a = '0;

  assign bus.mmu_mem_ready = mmu_ready_q;
  assign bus.mmu_data_out  = mmu_dout_q;

  function automatic logic [31:0] mmu_load(input logic [5:0] a, input logic [1:0] w,
                                           input logic s);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k <= int'(w); k++) r[8*k +: 8] = mem[a + 6'(k)];
    if (s && w == 2'd0) r = {{24{r[7]}}, r[7:0]};
    if (s && w == 2'd1) r = {{16{r[15]}}, r[15:0]};
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.mmu_read_enable || bus.mmu_write_enable) begin
      last_w <= bus.mmu_data_width;
      last_s <= bus.mmu_signed_read;
      last_a <= bus.mmu_address;
      if (bus.mmu_read_enable) begin
        rd_pulses  <= rd_pulses + 1;
        mmu_dout_q <= mmu_load(bus.mmu_address[5:0], bus.mmu_data_width,
                               bus.mmu_signed_read);
      end
      if (bus.mmu_write_enable) begin
        wr_pulses <= wr_pulses + 1;
        for (int k = 0; k <= int'(bus.mmu_data_width); k++)
          mem[bus.mmu_address[5:0] + 6'(k)] <= bus.mmu_data_in[8*k +: 8];
      end
      // Sub-word stores (read-modify-write) and word-crossing loads take one extra cycle.
      if (hang ||
          (bus.mmu_write_enable && bus.mmu_data_width != 2'd3) ||
          (bus.mmu_read_enable &&
           ({1'b0, bus.mmu_address[1:0]} + {1'b0, bus.mmu_data_width}) > 3'd3))
        mmu_ready_q <= 1'b0;
    end else if (!hang) begin
      mmu_ready_q <= 1'b1;
    end
  end

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rdp;
    int          wrp;
    logic        chk_ctl;
    logic [1:0]  width;
    logic        sgn;
  } vec_t;

  typedef struct {
    vec_t v;
    int   ref_cyc;
    int   rdp0;
    int   wrp0;
  } sb_t;

  sb_t  sb [$];
  vec_t vecs [$];

  function automatic vec_t mk(logic w, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                              logic [4:0] rd, logic [31:0] rdata, logic err, int lat,
                              int rdp, int wrp, logic chk_ctl, logic [1:0] width, logic sgn);
    vec_t v;
    v.w = w; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd; v.rdata = rdata;
    v.err = err; v.lat = lat; v.rdp = rdp; v.wrp = wrp; v.chk_ctl = chk_ctl;
    v.width = width; v.sgn = sgn;
    return v;
  endfunction

  always @(negedge clk) begin
    if (reset_n && bus.resp_valid) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_resp: got rd=%0d expected no response", bus.resp_rd);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk($sformatf("rdata rd%0d", e.v.rd), bus.resp_rdata, e.v.rdata);
        chk($sformatf("tag rd%0d", e.v.rd), 32'(bus.resp_rd), 32'(e.v.rd));
        chk($sformatf("error rd%0d", e.v.rd), 32'(bus.resp_error), 32'(e.v.err));
        chk($sformatf("latency rd%0d", e.v.rd), 32'(cyc - e.ref_cyc), 32'(e.v.lat));
        chk($sformatf("rd_pulses rd%0d", e.v.rd), 32'(rd_pulses - e.rdp0), 32'(e.v.rdp));
        chk($sformatf("wr_pulses rd%0d", e.v.rd), 32'(wr_pulses - e.wrp0), 32'(e.v.wrp));
        if (e.v.chk_ctl) begin
          chk($sformatf("width rd%0d", e.v.rd), 32'(last_w), 32'(e.v.width));
          chk($sformatf("signed rd%0d", e.v.rd), 32'(last_s), 32'(e.v.sgn));
          chk($sformatf("address rd%0d", e.v.rd), last_a, e.v.addr);
        end
      end
    end
  end

  task automatic send(input vec_t v, output int ref_cyc);
    sb_t e;
    int  n;
    @(negedge clk);
    bus.req_write  = v.w;
    bus.req_funct3 = v.f3;
    bus.req_addr   = v.addr;
    bus.req_wdata  = v.wdata;
    bus.req_rd     = v.rd;
    bus.req_valid  = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ref_cyc = cyc;
    if (!bus.req_ready) begin
      chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
    end else begin
      e.v = v;
      e.ref_cyc = cyc;
      e.rdp0 = rd_pulses;
      e.wrp0 = wr_pulses;
      sb.push_back(e);
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("response_wait", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r1, r2, rx;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = '0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = '0;
    for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
    {mem[3], mem[2], mem[1], mem[0]}     <= 32'h80112233;
    {mem[7], mem[6], mem[5], mem[4]}     <= 32'h77665544;
    {mem[11], mem[10], mem[9], mem[8]}   <= 32'hDEADBEEF;

    // w f3 addr wdata rd | rdata err lat rdp wrp chk width sgn
    vecs.push_back(mk(0, 3'b010, 32'h0100_0008, 0, 1, 32'hDEADBEEF, 0, 3, 1, 0, 1, 3, 1));
    vecs.push_back(mk(0, 3'b000, 32'h0100_0003, 0, 2, 32'hFFFFFF80, 0, 3, 1, 0, 1, 0, 1));
    vecs.push_back(mk(0, 3'b100, 32'h0100_0003, 0, 3, 32'h00000080, 0, 3, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 3'b001, 32'h0100_0002, 0, 4, 32'hFFFF8011, 0, 3, 1, 0, 1, 1, 1));
    vecs.push_back(mk(0, 3'b101, 32'h0100_0000, 0, 7, 32'h00002233, 0, 3, 1, 0, 1, 1, 0));
    vecs.push_back(mk(1, 3'b001, 32'h0100_0002, 32'h0000ABCD, 8, 0, 0, 4, 0, 1, 1, 1, 0));
    vecs.push_back(mk(0, 3'b010, 32'h0100_0000, 0, 9, 32'hABCD2233, 0, 3, 1, 0, 1, 3, 1));
    vecs.push_back(mk(1, 3'b010, 32'h0100_0001, 32'h11111111, 10, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b010, 32'h0100_0005, 0, 11, 32'hEF776655, 0, 4, 1, 0, 1, 3, 1));
    vecs.push_back(mk(0, 3'b011, 32'h0100_0008, 0, 12, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3'b000, 32'h0100_0007, 32'hFFFFFF5A, 13, 0, 0, 4, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 3'b100, 32'h0100_0007, 0, 14, 32'h0000005A, 0, 3, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 3'b010, 32'h0100_000C, 32'h12345678, 15, 0, 0, 3, 0, 1, 1, 3, 0));
    vecs.push_back(mk(0, 3'b010, 32'h0100_000C, 0, 16, 32'h12345678, 0, 3, 1, 0, 1, 3, 1));
    vecs.push_back(mk(1, 3'b100, 32'h0100_0000, 0, 17, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b110, 32'h0100_0000, 0, 18, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 3'b111, 32'h0100_0000, 0, 19, 0, 1, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3'b001, 32'h0100_0003, 32'h0000BEEF, 20, 0, 1, 1, 0, 0, 0, 0, 0));

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("reset enables", 32'({bus.mmu_read_enable, bus.mmu_write_enable}), 32'd0);
    chk("reset width", 32'(bus.mmu_data_width), 32'd0);
    chk("reset address", bus.mmu_address, 32'd0);

    foreach (vecs[i]) begin
      send(vecs[i], rx);
      drain();
    end

    // Back-to-back: second request accepted in the cycle the first response appears.
    send(mk(0, 3'b010, 32'h0100_0008, 0, 5, 32'hDEADBEEF, 0, 3, 1, 0, 1, 3, 1), r1);
    send(mk(0, 3'b010, 32'h0100_000C, 0, 6, 32'h12345678, 0, 3, 1, 0, 1, 3, 1), r2);
    drain();
    chk("b2b accept spacing", 32'(r2 - r1), 32'd3);

    // Timeout: mmu never comes back after the read pulse.
    hang = 1'b1;
    send(mk(0, 3'b010, 32'h0100_0008, 0, 21, 0, 1, Timeout + 2, 1, 0, 1, 3, 1), rx);
    drain();
    @(negedge clk);
    chk("timeout req_ready", 32'(bus.req_ready), 32'd1);
    hang = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset while in WAIT abandons the access.
    hang = 1'b1;
    send(mk(0, 3'b010, 32'h0100_0004, 32'h5555AAAA, 22, 0, 0, 0, 0, 0, 0, 0, 0), rx);
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    sb.delete();
    #1;
    chk("async req_ready", 32'(bus.req_ready), 32'd1);
    chk("async resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("async resp_rd", 32'(bus.resp_rd), 32'd0);
    chk("async resp_rdata", bus.resp_rdata, 32'd0);
    chk("async address", bus.mmu_address, 32'd0);
    chk("async width", 32'(bus.mmu_data_width), 32'd0);
    chk("async signed", 32'(bus.mmu_signed_read), 32'd0);
    chk("async enables", 32'({bus.mmu_read_enable, bus.mmu_write_enable}), 32'd0);
    hang = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    send(mk(0, 3'b010, 32'h0100_0008, 0, 23, 32'hDEADBEEF, 0, 3, 1, 0, 1, 3, 1), rx);
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
